// File: rtl/dot_product_accum.sv
// Three-stage DIM-lane dot-product engine with multi-beat accumulation,
// per-beat signed/unsigned lanes, valid/ready handshakes and a sticky overflow flag.
module dot_product_accum #(
  parameter int unsigned DIM          = 10,
  parameter int unsigned A_DATA_WIDTH = 16,
  parameter int unsigned B_DATA_WIDTH = 16,
  parameter int unsigned ACC_WIDTH    = 40
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic [A_DATA_WIDTH*DIM-1:0]  A,
  input  logic [B_DATA_WIDTH*DIM-1:0]  B,
  input  logic                         inValid,
  output logic                         inReady,
  input  logic                         inFirst,
  input  logic                         inLast,
  input  logic                         signedMode,
  output logic [ACC_WIDTH-1:0]         DotProduct,
  output logic                         overflow,
  output logic                         outValid,
  input  logic                         outReady
);

  localparam int unsigned PW = A_DATA_WIDTH + B_DATA_WIDTH;

  logic                 stall, accept;

  logic [PW-1:0]        prod_d [DIM];
  logic [PW-1:0]        prod_q [DIM];
  logic                 s1_valid_q, s1_first_q, s1_last_q, s1_signed_q;

  logic [ACC_WIDTH-1:0] sum_d, sum_q;
  logic                 s2_valid_q, s2_first_q, s2_last_q, s2_signed_q;

  logic [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                 ovf_d, ovf_q, open_q;
  logic [ACC_WIDTH:0]   add_full;
  logic                 restart, wrap;

  logic [ACC_WIDTH-1:0] dp_q;
  logic                 dp_ovf_q, out_valid_q;

  assign stall      = out_valid_q & ~outReady;
  assign inReady    = ~stall;
  assign accept     = inValid & inReady;
  assign DotProduct = dp_q;
  assign overflow   = dp_ovf_q;
  assign outValid   = out_valid_q;

  // Operands extended to PW bits; the low PW bits of the product are exact in both modes.
  always_comb begin
    for (int unsigned i = 0; i < DIM; i++) begin
      prod_d[i] = {{(PW-A_DATA_WIDTH){signedMode & A[i*A_DATA_WIDTH + A_DATA_WIDTH - 1]}},
                   A[i*A_DATA_WIDTH +: A_DATA_WIDTH]}
                * {{(PW-B_DATA_WIDTH){signedMode & B[i*B_DATA_WIDTH + B_DATA_WIDTH - 1]}},
                   B[i*B_DATA_WIDTH +: B_DATA_WIDTH]};
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < DIM; i++) begin
      sum_d = sum_d + {{(ACC_WIDTH-PW){s1_signed_q & prod_q[i][PW-1]}}, prod_q[i]};
    end
  end

  always_comb begin
    add_full = {1'b0, acc_q} + {1'b0, sum_q};
    restart  = s2_first_q | ~open_q;
    if (s2_signed_q) begin
      wrap = (acc_q[ACC_WIDTH-1] == sum_q[ACC_WIDTH-1]) &&
             (add_full[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
    end else begin
      wrap = add_full[ACC_WIDTH];
    end
    acc_d = restart ? sum_q : add_full[ACC_WIDTH-1:0];
    ovf_d = restart ? 1'b0 : (ovf_q | wrap);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      prod_q      <= '{default: '0};
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_signed_q <= 1'b0;
      sum_q       <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_signed_q <= 1'b0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      open_q      <= 1'b0;
      dp_q        <= '0;
      dp_ovf_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      s1_valid_q <= accept;
      if (accept) begin
        prod_q      <= prod_d;
        s1_first_q  <= inFirst;
        s1_last_q   <= inLast;
        s1_signed_q <= signedMode;
      end

      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        sum_q       <= sum_d;
        s2_first_q  <= s1_first_q;
        s2_last_q   <= s1_last_q;
        s2_signed_q <= s1_signed_q;
      end

      // Not stalled means any held result was consumed on this edge.
      out_valid_q <= 1'b0;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          dp_q        <= acc_d;
          dp_ovf_q    <= ovf_d;
          out_valid_q <= 1'b1;
          acc_q       <= '0;
          ovf_q       <= 1'b0;
          open_q      <= 1'b0;
        end else begin
          acc_q  <= acc_d;
          ovf_q  <= ovf_d;
          open_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_accum.sv
// Scoreboard bench for dot_product_accum: stimulus pushes expected results from an
// integer-arithmetic reference model; a monitor pops and compares on each output handshake.
module tb_dot_product_accum;

  localparam int DIM = 10;
  localparam int AW  = 16;
  localparam int BW  = 16;
  localparam int AC  = 40;
  localparam longint FULL = longint'(1) << AC;
  localparam longint HALF = longint'(1) << (AC - 1);

  logic                Clock = 1'b0;
  logic                Reset;
  logic [AW*DIM-1:0]   A;
  logic [BW*DIM-1:0]   B;
  logic                inValid, inReady, inFirst, inLast, signedMode;
  logic [AC-1:0]       DotProduct;
  logic                overflow, outValid, outReady;

  dot_product_accum #(
    .DIM(DIM), .A_DATA_WIDTH(AW), .B_DATA_WIDTH(BW), .ACC_WIDTH(AC)
  ) dut (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B),
    .inValid(inValid), .inReady(inReady), .inFirst(inFirst), .inLast(inLast),
    .signedMode(signedMode), .DotProduct(DotProduct), .overflow(overflow),
    .outValid(outValid), .outReady(outReady)
  );

  always #5 Clock = ~Clock;

  typedef struct {
    logic [AC-1:0] dp;
    logic          ovf;
    bit            has_c;
    logic [AC-1:0] cdp;
    logic          covf;
  } exp_t;

  exp_t          sbq[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  bit            rand_bp  = 1'b0;

  logic [AC-1:0] macc;
  logic          movf;
  bit            m_open;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW*DIM-1:0] fill_a(input logic [AW-1:0] v);
    return {DIM{v}};
  endfunction

  function automatic logic [BW*DIM-1:0] fill_b(input logic [BW-1:0] v);
    return {DIM{v}};
  endfunction

  function automatic longint beat_sum(input logic [AW*DIM-1:0] a, input logic [BW*DIM-1:0] b,
                                      input bit sm);
    longint s, x, y;
    logic [AW-1:0] av;
    logic [BW-1:0] bv;
    s = 0;
    for (int i = 0; i < DIM; i++) begin
      av = a[i*AW +: AW];
      bv = b[i*BW +: BW];
      x  = sm ? longint'($signed(av)) : longint'(av);
      y  = sm ? longint'($signed(bv)) : longint'(bv);
      s  = s + x * y;
    end
    return s;
  endfunction

  // Reference: true-integer accumulation, wrap detected as leaving the representable range.
  task automatic model_beat(input logic [AW*DIM-1:0] a, input logic [BW*DIM-1:0] b,
                            input bit f, input bit l, input bit sm,
                            input bit hc, input logic [AC-1:0] cdp, input bit covf);
    longint s, cur, t;
    bit     w;
    exp_t   e;
    s = beat_sum(a, b, sm);
    if (f || !m_open) begin
      macc = s[AC-1:0];
      movf = 1'b0;
    end else begin
      cur  = sm ? longint'($signed(macc)) : longint'(macc);
      t    = cur + s;
      w    = sm ? ((t >= HALF) || (t < -HALF)) : (t >= FULL);
      macc = t[AC-1:0];
      movf = movf | w;
    end
    if (l) begin
      e.dp = macc; e.ovf = movf; e.has_c = hc; e.cdp = cdp; e.covf = covf;
      sbq.push_back(e);
      macc   = '0;
      movf   = 1'b0;
      m_open = 1'b0;
    end else begin
      m_open = 1'b1;
    end
  endtask

  task automatic send_beat(input logic [AW*DIM-1:0] a, input logic [BW*DIM-1:0] b,
                           input bit f, input bit l, input bit sm,
                           input bit hc, input logic [AC-1:0] cdp, input bit covf);
    bit          ok;
    int unsigned g;
    A = a; B = b; inFirst = f; inLast = l; signedMode = sm; inValid = 1'b1;
    ok = 1'b0; g = 0;
    while (!ok && g < 2000) begin
      if (rand_bp) outReady = ($urandom_range(0, 3) != 0);
      @(negedge Clock);
      ok = inReady;
      @(posedge Clock);
      #1;
      g++;
    end
    inValid = 1'b0;
    chk("beat_accepted", ok, 1);
    if (ok) model_beat(a, b, f, l, sm, hc, cdp, covf);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge Clock);
      #1;
    end
  endtask

  task automatic drain();
    int unsigned g;
    g = 0;
    rand_bp  = 1'b0;
    outReady = 1'b1;
    while (sbq.size() != 0 && g < 200) begin
      @(posedge Clock);
      #1;
      g++;
    end
    chk("drain_empty", sbq.size(), 0);
  endtask

  // Monitor: compare every output handshake against the head of the scoreboard.
  always @(negedge Clock) begin
    exp_t e;
    if (!Reset && outValid && outReady) begin
      chk("sb_pending", (sbq.size() != 0), 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("dp_model", DotProduct, e.dp);
        chk("ovf_model", overflow, e.ovf);
        if (e.has_c) begin
          chk("dp_const", DotProduct, e.cdp);
          chk("ovf_const", overflow, e.covf);
        end
      end
    end
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW*DIM-1:0] ra;
    logic [BW*DIM-1:0] rb;
    int unsigned       len, kind;
    bit                sm, abandon, f, l;

    Reset = 1'b1; A = '0; B = '0; inValid = 1'b0; inFirst = 1'b0; inLast = 1'b0;
    signedMode = 1'b0; outReady = 1'b1;
    macc = '0; movf = 1'b0; m_open = 1'b0;
    idle(2);
    chk("rst_dp", DotProduct, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_outvalid", outValid, 0);
    chk("rst_inready", inReady, 1);
    Reset = 1'b0;
    idle(1);

    // Single beat, unsigned 8*8 over 10 lanes, with latency check
    send_beat(fill_a(16'd8), fill_b(16'd8), 1, 1, 0, 1, 40'd640, 0);
    @(negedge Clock); chk("lat_edge_k", outValid, 0);
    @(negedge Clock); chk("lat_edge_k1", outValid, 0);
    @(negedge Clock); chk("lat_edge_k2", outValid, 1);
    @(negedge Clock); chk("one_cycle_valid", outValid, 0);
    @(posedge Clock); #1;
    drain();

    // Signed vs unsigned interpretation of 16'hFFFF * 2
    send_beat(fill_a(16'hFFFF), fill_b(16'd2), 1, 1, 1, 1, 40'hFFFFFFFFEC, 0);
    send_beat(fill_a(16'hFFFF), fill_b(16'd2), 1, 1, 0, 1, 40'd1310700, 0);
    drain();

    // Three-beat vector
    send_beat(fill_a(16'd8), fill_b(16'd8), 1, 0, 0, 0, '0, 0);
    send_beat(fill_a(16'd8), fill_b(16'd8), 0, 0, 0, 0, '0, 0);
    send_beat(fill_a(16'd8), fill_b(16'd8), 0, 1, 0, 1, 40'd1920, 0);
    @(negedge Clock); chk("no_early_out", outValid, 0);
    @(posedge Clock); #1;
    drain();

    // Backpressure: three results queued behind a stalled output, a fourth offered
    outReady = 1'b0;
    send_beat(fill_a(16'd3), fill_b(16'd5), 1, 1, 0, 1, 40'd150, 0);
    send_beat(fill_a(16'd1), fill_b(16'd1), 1, 1, 0, 1, 40'd10, 0);
    send_beat(fill_a(16'd2), fill_b(16'd3), 1, 1, 0, 1, 40'd60, 0);
    A = fill_a(16'd7); B = fill_b(16'd9); inFirst = 1'b1; inLast = 1'b1;
    signedMode = 1'b0; inValid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("stall_inready", inReady, 0);
      chk("stall_outvalid", outValid, 1);
      chk("stall_dp", DotProduct, 40'd150);
    end
    @(posedge Clock); #1;
    outReady = 1'b1;
    send_beat(fill_a(16'd7), fill_b(16'd9), 1, 1, 0, 1, 40'd630, 0);
    drain();

    // Unsigned overflow boundary: 25 beats fit, 26 wrap
    for (int i = 0; i < 25; i++)
      send_beat(fill_a(16'hFFFF), fill_b(16'hFFFF), (i == 0), (i == 24), 0, (i == 24),
                40'd1073709056250, 0);
    drain();
    for (int i = 0; i < 26; i++)
      send_beat(fill_a(16'hFFFF), fill_b(16'hFFFF), (i == 0), (i == 25), 0, (i == 25),
                40'd17145790724, 1);
    drain();

    // Signed overflow: 52 beats of (-32768)^2 per lane exceeds the positive range
    for (int i = 0; i < 52; i++)
      send_beat(fill_a(16'h8000), fill_b(16'h8000), (i == 0), (i == 51), 1, 0, '0, 0);
    drain();

    // Reset mid-vector discards partial state
    send_beat(fill_a(16'd8), fill_b(16'd8), 1, 0, 0, 0, '0, 0);
    send_beat(fill_a(16'd8), fill_b(16'd8), 0, 0, 0, 0, '0, 0);
    Reset = 1'b1;
    @(negedge Clock); chk("midrst_outvalid", outValid, 0);
    @(posedge Clock); #1;
    @(negedge Clock);
    chk("midrst_outvalid2", outValid, 0);
    chk("midrst_dp", DotProduct, 0);
    @(posedge Clock); #1;
    Reset = 1'b0;
    macc = '0; movf = 1'b0; m_open = 1'b0;
    send_beat(fill_a(16'd8), fill_b(16'd8), 1, 1, 0, 1, 40'd640, 0);
    drain();

    // Randomised vectors with random backpressure, gaps and abandoned vectors
    rand_bp = 1'b1;
    for (int v = 0; v < 60; v++) begin
      len     = $urandom_range(1, 4);
      sm      = ($urandom_range(0, 1) != 0);
      kind    = $urandom_range(0, 3);
      abandon = ($urandom_range(0, 9) == 0);
      for (int unsigned j = 0; j < len; j++) begin
        for (int k = 0; k < DIM; k++) begin
          case (kind)
            1:       begin ra[k*AW +: AW] = 16'hFFFF; rb[k*BW +: BW] = 16'hFFFF; end
            2:       begin ra[k*AW +: AW] = 16'h8000; rb[k*BW +: BW] = 16'h7FFF; end
            default: begin ra[k*AW +: AW] = AW'($urandom); rb[k*BW +: BW] = BW'($urandom); end
          endcase
        end
        f = (j == 0) ? ($urandom_range(0, 9) != 0) : 1'b0;
        l = (j == len - 1) && !abandon;
        send_beat(ra, rb, f, l, sm, 0, '0, 0);
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
    end
    drain();
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
